// File: rtl/sfr_ext.sv
// sfr_ext: writable SFR bank at addresses 8..15.
// It holds a cycle counter, a retired-instruction counter, a countdown timer
// with an interrupt, and two scratch registers. dout is 0 outside 8..E so the
// CPU read mux can OR it with the read-only SFR file.
module sfr_ext #(
  parameter int          WIDTH   = 32,
  parameter logic [31:0] SCR_RST = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       addr,
  input  logic             cen,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  input  logic             retire,
  output logic [WIDTH-1:0] dout,
  output logic             timer_irq
);

  localparam logic [3:0] A_CYC  = 4'h8;
  localparam logic [3:0] A_RET  = 4'h9;
  localparam logic [3:0] A_TMR  = 4'hA;
  localparam logic [3:0] A_TCTL = 4'hB;
  localparam logic [3:0] A_TRLD = 4'hC;
  localparam logic [3:0] A_SCR0 = 4'hD;
  localparam logic [3:0] A_SCR1 = 4'hE;

  logic [WIDTH-1:0] cyc, ret, tmr, trld, scr0, scr1;
  logic             en, ar, expf, ie;

  logic wr;
  logic tick, expire;

  assign wr = cen & wen;

  // The timer steps only when enabled and not parked at 0. A TMR write in the
  // same cycle overrides the step, so an expiry that would happen then is dropped.
  assign tick   = en && (tmr != '0);
  assign expire = tick && (tmr == WIDTH'(1)) && !(wr && addr == A_TMR);

  // Free-running counters; a write wins over that cycle's increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc <= '0;
      ret <= '0;
    end else begin
      cyc <= (wr && addr == A_CYC) ? din : cyc + WIDTH'(1);
      if (wr && addr == A_RET)
        ret <= din;
      else if (retire)
        ret <= ret + WIDTH'(1);
    end
  end

  // Timer count, control and reload. Expiry sets EXP even when a W1C clear
  // lands in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr  <= '0;
      trld <= '0;
      en   <= 1'b0;
      ar   <= 1'b0;
      expf <= 1'b0;
      ie   <= 1'b0;
    end else begin
      if (wr && addr == A_TMR)
        tmr <= din;
      else if (tick)
        tmr <= (tmr == WIDTH'(1)) ? (ar ? trld : '0) : tmr - WIDTH'(1);

      if (wr && addr == A_TRLD)
        trld <= din;

      if (wr && addr == A_TCTL) begin
        en   <= din[0];
        ar   <= din[1];
        ie   <= din[3];
        expf <= expire | (expf & ~din[2]);
      end else begin
        expf <= expf | expire;
      end
    end
  end

  // Scratch registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scr0 <= WIDTH'(SCR_RST);
      scr1 <= WIDTH'(SCR_RST);
    end else begin
      if (wr && addr == A_SCR0) scr0 <= din;
      if (wr && addr == A_SCR1) scr1 <= din;
    end
  end

  // Read mux: not gated by cen; unmapped addresses read 0.
  always_comb begin
    dout = '0;
    case (addr)
      A_CYC:   dout = cyc;
      A_RET:   dout = ret;
      A_TMR:   dout = tmr;
      A_TCTL:  dout = WIDTH'({ie, expf, ar, en});
      A_TRLD:  dout = trld;
      A_SCR0:  dout = scr0;
      A_SCR1:  dout = scr1;
      default: dout = '0;
    endcase
  end

  assign timer_irq = expf & ie;

endmodule

// File: tb/tb_sfr_ext.sv
// Directed self-checking bench for sfr_ext. Inputs change and outputs are
// sampled on the falling edge; the DUT updates on the rising edge.
module tb_sfr_ext;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic [3:0]       addr;
  logic             cen;
  logic             wen;
  logic [WIDTH-1:0] din;
  logic             retire;
  logic [WIDTH-1:0] dout;
  logic             timer_irq;

  int errors = 0;
  int checks = 0;

  sfr_ext #(.WIDTH(WIDTH), .SCR_RST(32'h0)) dut (
    .clk(clk), .reset(reset), .addr(addr), .cen(cen), .wen(wen),
    .din(din), .retire(retire), .dout(dout), .timer_irq(timer_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Called at a falling edge; the write lands on the next rising edge and the
  // task returns at the following falling edge.
  task automatic wr(input logic [3:0] a, input logic [WIDTH-1:0] d);
    addr = a; din = d; cen = 1'b1; wen = 1'b1;
    @(negedge clk);
    cen = 1'b0; wen = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; addr = 4'h8; cen = 1'b0; wen = 1'b0; din = '0; retire = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (dout !== 32'h0) begin errors++; $display("FAIL rst_cyc got=%h exp=%h", dout, 32'h0); end
    checks++;
    if (timer_irq !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b exp=0", timer_irq); end
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    addr = 4'h8; #1;
    checks++;
    if (dout !== 32'd10) begin errors++; $display("FAIL cyc_10 got=%h exp=%h", dout, 32'd10); end
    addr = 4'h9; #1;
    checks++;
    if (dout !== 32'd0) begin errors++; $display("FAIL ret_0 got=%h exp=%h", dout, 32'd0); end
    checks++;
    if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_idle got=%b exp=0", timer_irq); end
  endtask

  task automatic test_cyc_wrap();
    logic [WIDTH-1:0] exp_v [3];
    exp_v = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
    wr(4'h8, 32'hFFFF_FFFE);
    addr = 4'h8;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if (dout !== exp_v[k]) begin errors++; $display("FAIL cyc_wrap[%0d] got=%h exp=%h", k, dout, exp_v[k]); end
    end
    @(negedge clk);
  endtask

  task automatic test_timer_autoreload();
    logic [WIDTH-1:0] exp_t [6];
    logic             exp_i [6];
    exp_t = '{32'd3, 32'd2, 32'd1, 32'd3, 32'd2, 32'd1};
    exp_i = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    wr(4'hC, 32'd3);
    wr(4'hA, 32'd3);
    wr(4'hB, 32'hB);
    addr = 4'hA;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if (dout !== exp_t[k]) begin errors++; $display("FAIL tmr_seq[%0d] got=%h exp=%h", k, dout, exp_t[k]); end
      checks++;
      if (timer_irq !== exp_i[k]) begin errors++; $display("FAIL irq_seq[%0d] got=%b exp=%b", k, timer_irq, exp_i[k]); end
    end
    // W1C on a cycle that expires again: the new expiry keeps EXP set.
    wr(4'hB, 32'hF);
    addr = 4'hB; #1;
    checks++;
    if (dout !== 32'hF) begin errors++; $display("FAIL tctl_setwins got=%h exp=%h", dout, 32'hF); end
    checks++;
    if (timer_irq !== 1'b1) begin errors++; $display("FAIL irq_setwins got=%b exp=1", timer_irq); end
    addr = 4'hA; #1;
    checks++;
    if (dout !== 32'd3) begin errors++; $display("FAIL tmr_reload got=%h exp=%h", dout, 32'd3); end
    // Plain W1C clears.
    wr(4'hB, 32'hF);
    addr = 4'hB; #1;
    checks++;
    if (dout !== 32'hB) begin errors++; $display("FAIL tctl_w1c got=%h exp=%h", dout, 32'hB); end
    checks++;
    if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_w1c got=%b exp=0", timer_irq); end
    wr(4'hB, 32'h0);  // tmr 2->1 on this edge, then halted
    addr = 4'hA; #1;
    checks++;
    if (dout !== 32'd1) begin errors++; $display("FAIL tmr_halt got=%h exp=%h", dout, 32'd1); end
  endtask

  task automatic test_expiry_write();
    wr(4'hB, 32'h1);  // EN takes effect after this edge, tmr still 1
    addr = 4'hA; #1;
    checks++;
    if (dout !== 32'd1) begin errors++; $display("FAIL en_delay got=%h exp=%h", dout, 32'd1); end
    wr(4'hA, 32'd5);  // lands on the expiry edge
    addr = 4'hA; #1;
    checks++;
    if (dout !== 32'd5) begin errors++; $display("FAIL tmr_wrwin got=%h exp=%h", dout, 32'd5); end
    addr = 4'hB; #1;
    checks++;
    if (dout !== 32'h1) begin errors++; $display("FAIL exp_cancel got=%h exp=%h", dout, 32'h1); end
    @(negedge clk);
    addr = 4'hA; #1;
    checks++;
    if (dout !== 32'd4) begin errors++; $display("FAIL tmr_after got=%h exp=%h", dout, 32'd4); end
    wr(4'hB, 32'h0);
  endtask

  task automatic test_retire();
    int pat [11];
    pat = '{1, 0, 1, 1, 0, 1, 0, 1, 0, 1, 1};
    addr = 4'h9;
    for (int i = 0; i < 11; i++) begin
      #1;
      if (i == 5) begin
        checks++;
        if (dout !== 32'd3) begin errors++; $display("FAIL ret_pre got=%h exp=%h", dout, 32'd3); end
      end
      if (i == 6) begin
        checks++;
        if (dout !== 32'd100) begin errors++; $display("FAIL ret_wrwin got=%h exp=%h", dout, 32'd100); end
      end
      retire = pat[i][0];
      cen = (i == 5); wen = (i == 5); din = 32'd100;
      @(negedge clk);
    end
    retire = 1'b0; cen = 1'b0; wen = 1'b0;
    #1;
    checks++;
    if (dout !== 32'd103) begin errors++; $display("FAIL ret_final got=%h exp=%h", dout, 32'd103); end
  endtask

  task automatic test_unmapped_and_reset();
    logic [3:0] a;
    wr(4'hD, 32'h1111);
    wr(4'hE, 32'h2222);
    wr(4'h3, 32'hDEAD);
    wr(4'hF, 32'hDEAD);
    for (int i = 0; i < 9; i++) begin
      a = (i == 8) ? 4'hF : 4'(i);
      addr = a; #1;
      checks++;
      if (dout !== 32'h0) begin errors++; $display("FAIL unmapped[%h] got=%h exp=0", a, dout); end
    end
    addr = 4'hD; #1;
    checks++;
    if (dout !== 32'h1111) begin errors++; $display("FAIL scr0 got=%h exp=%h", dout, 32'h1111); end
    addr = 4'hE; #1;
    checks++;
    if (dout !== 32'h2222) begin errors++; $display("FAIL scr1 got=%h exp=%h", dout, 32'h2222); end
    // Get the timer to expire with IE set, then reset asynchronously mid-count.
    wr(4'hC, 32'd5);
    wr(4'hA, 32'd2);
    wr(4'hB, 32'hB);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (timer_irq !== 1'b1) begin errors++; $display("FAIL irq_pre_rst got=%b exp=1", timer_irq); end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_in_rst got=%b exp=0", timer_irq); end
    for (int i = 8; i < 15; i++) begin
      addr = 4'(i); #1;
      checks++;
      if (dout !== 32'h0) begin errors++; $display("FAIL rst_reg[%h] got=%h exp=0", addr, dout); end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cyc_wrap();
    test_timer_autoreload();
    test_expiry_write();
    test_retire();
    test_unmapped_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
